// File: rtl/id_ex_stage_reg_pkg.sv
// rtl/id_ex_stage_reg_pkg.sv - MIPS pipeline definitions shared by the ID/EX stage
// Opcodes, ALUOp encodings, control-word packing and the control scrub helper.
package id_ex_stage_reg_pkg;

    localparam logic [5:0] R_FORMAT = 6'h00;
    localparam logic [5:0] LW       = 6'h23;
    localparam logic [5:0] SW       = 6'h2b;
    localparam logic [5:0] J        = 6'h02;
    localparam logic [5:0] BEQ      = 6'h04;
    localparam logic [5:0] BNE      = 6'h05;
    localparam logic [5:0] ORI      = 6'h0d;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam int CTRL_W = 13;

    // Bit positions within the packed control word.
    localparam int CTRL_REGDST   = 12;
    localparam int CTRL_ALUSRC   = 11;
    localparam int CTRL_MEMTOREG = 10;
    localparam int CTRL_REGWRITE = 9;
    localparam int CTRL_MEMREAD  = 8;
    localparam int CTRL_MEMWRITE = 7;
    localparam int CTRL_BRANCH   = 6;
    localparam int CTRL_JUMP     = 5;
    localparam int CTRL_ALUOP_HI = 4;
    localparam int CTRL_ALUOP_LO = 3;
    localparam int CTRL_BEQBNE   = 2;
    localparam int CTRL_SIGN     = 1;

    // State-changing bits pass only when they are a definite 1, so an
    // undecoded opcode that leaves them unknown can never write state.
    function automatic logic [CTRL_W-1:0] scrub_ctrl(input logic [CTRL_W-1:0] c);
        logic [CTRL_W-1:0] r;
        r = c;
        r[CTRL_REGWRITE] = (c[CTRL_REGWRITE] === 1'b1);
        r[CTRL_MEMREAD]  = (c[CTRL_MEMREAD]  === 1'b1);
        r[CTRL_MEMWRITE] = (c[CTRL_MEMWRITE] === 1'b1);
        r[CTRL_BRANCH]   = (c[CTRL_BRANCH]   === 1'b1);
        r[CTRL_JUMP]     = (c[CTRL_JUMP]     === 1'b1);
        return r;
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_imm_extend.sv
// rtl/id_ex_stage_reg_imm_extend.sv - combinational sign/zero extension of the raw immediate
module imm_extend #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic [IMM_W-1:0]  imm,
    input  logic              sign,
    output logic [DATA_W-1:0] imm_ext
);

    always_comb begin
        if (sign) begin
            imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        end else begin
            imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm};
        end
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with stall, flush and control scrub
// Optional bubble/stall performance counters when IDEX_PERF_CNT_EN is defined.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int IMM_W      = 16
`ifdef IDEX_PERF_CNT_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [CTRL_W-1:0]     id_ctrl,
    input  logic [DATA_W-1:0]     id_pc4,
    input  logic [DATA_W-1:0]     id_rd1,
    input  logic [DATA_W-1:0]     id_rd2,
    input  logic [IMM_W-1:0]      id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [5:0]            id_funct,
    output logic                  ex_valid,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic [DATA_W-1:0]     ex_pc4,
    output logic [DATA_W-1:0]     ex_rd1,
    output logic [DATA_W-1:0]     ex_rd2,
    output logic [DATA_W-1:0]     ex_imm_ext,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [5:0]            ex_funct
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      bubble_cnt,
    output logic [CNT_W-1:0]      stall_cnt
`endif
);

    logic                  sign_eff;
    logic [DATA_W-1:0]     imm_ext;
    logic                  load_data;

    logic                  valid_q, valid_d;
    logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
    logic [DATA_W-1:0]     pc4_q, pc4_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [REG_ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [5:0]            funct_q, funct_d;

    // An unknown Sign bit falls back to sign extension.
    assign sign_eff = (id_ctrl[CTRL_SIGN] !== 1'b0);

    imm_extend #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_imm_extend (
        .imm     (id_imm),
        .sign    (sign_eff),
        .imm_ext (imm_ext)
    );

    // Data fields follow the input on flush too; only ctrl/valid carry the bubble.
    assign load_data = flush | ~stall;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        pc4_d   = pc4_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        funct_d = funct_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (!stall) begin
            valid_d = id_valid;
            ctrl_d  = id_valid ? scrub_ctrl(id_ctrl) : '0;
        end
        if (load_data) begin
            pc4_d   = id_pc4;
            rd1_d   = id_rd1;
            rd2_d   = id_rd2;
            imm_d   = imm_ext;
            rs_d    = id_rs;
            rt_d    = id_rt;
            rd_d    = id_rd;
            funct_d = id_funct;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pc4_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            funct_q <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            pc4_q   <= pc4_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            funct_q <= funct_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_ctrl    = ctrl_q;
    assign ex_pc4     = pc4_q;
    assign ex_rd1     = rd1_q;
    assign ex_rd2     = rd2_q;
    assign ex_imm_ext = imm_q;
    assign ex_rs      = rs_q;
    assign ex_rt      = rt_q;
    assign ex_rd      = rd_q;
    assign ex_funct   = funct_q;

`ifdef IDEX_PERF_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, (flush | (~stall & ~id_valid))};
        stall_cnt_d  = stall_cnt_q + {{(CNT_W-1){1'b0}}, (stall & ~flush)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - self-checking bench for id_ex_stage_reg against a behavioural model
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, id_valid;
    logic [12:0] id_ctrl;
    logic [31:0] id_pc4, id_rd1, id_rd2;
    logic [15:0] id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [5:0]  id_funct;

    logic        ex_valid;
    logic [12:0] ex_ctrl;
    logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm_ext;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [5:0]  ex_funct;
`ifdef IDEX_PERF_CNT_EN
    logic [31:0] bubble_cnt, stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    // Behavioural model of what EX must be showing.
    logic        m_valid;
    logic [12:0] m_ctrl;
    logic [31:0] m_pc4, m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [5:0]  m_funct;
    logic [31:0] m_bub, m_stl;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_ctrl    (id_ctrl),
        .id_pc4     (id_pc4),
        .id_rd1     (id_rd1),
        .id_rd2     (id_rd2),
        .id_imm     (id_imm),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .id_funct   (id_funct),
        .ex_valid   (ex_valid),
        .ex_ctrl    (ex_ctrl),
        .ex_pc4     (ex_pc4),
        .ex_rd1     (ex_rd1),
        .ex_rd2     (ex_rd2),
        .ex_imm_ext (ex_imm_ext),
        .ex_rs      (ex_rs),
        .ex_rt      (ex_rt),
        .ex_rd      (ex_rd),
        .ex_funct   (ex_funct)
`ifdef IDEX_PERF_CNT_EN
        ,
        .bubble_cnt (bubble_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_valid = 0; m_ctrl = 0; m_pc4 = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
        m_rs = 0; m_rt = 0; m_rd = 0; m_funct = 0; m_bub = 0; m_stl = 0;
    endtask

    always @(negedge rst_n) model_clear();

    always @(posedge clk) begin
        if (rst_n) begin
            logic bubble, load;
            bubble = flush || (!stall && !id_valid);
            load   = flush || !stall;
            if (stall && !flush) m_stl = m_stl + 1;
            if (bubble) m_bub = m_bub + 1;
            if (bubble) begin
                m_valid = 0;
                m_ctrl  = 0;
            end else if (load) begin
                m_valid = 1;
                m_ctrl  = id_ctrl;
                for (int b = 5; b <= 9; b++) m_ctrl[b] = (id_ctrl[b] === 1'b1);
            end
            if (load) begin
                m_pc4 = id_pc4; m_rd1 = id_rd1; m_rd2 = id_rd2;
                m_imm = (id_ctrl[1] !== 1'b0) ? 32'($signed(id_imm)) : 32'(id_imm);
                m_rs = id_rs; m_rt = id_rt; m_rd = id_rd; m_funct = id_funct;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ex_valid", 64'(ex_valid), 64'(m_valid));
            chk("ex_ctrl", 64'(ex_ctrl), 64'(m_ctrl));
            chk("ex_pc4", 64'(ex_pc4), 64'(m_pc4));
            chk("ex_rd1", 64'(ex_rd1), 64'(m_rd1));
            chk("ex_rd2", 64'(ex_rd2), 64'(m_rd2));
            chk("ex_imm_ext", 64'(ex_imm_ext), 64'(m_imm));
            chk("ex_regs", {49'd0, ex_rs, ex_rt, ex_rd}, {49'd0, m_rs, m_rt, m_rd});
            chk("ex_funct", 64'(ex_funct), 64'(m_funct));
`ifdef IDEX_PERF_CNT_EN
            chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
            chk("stall_cnt", 64'(stall_cnt), 64'(m_stl));
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_id();
        id_ctrl = 13'($urandom) & 13'h1FFE;
        id_pc4 = $urandom; id_rd1 = $urandom; id_rd2 = $urandom;
        id_imm = 16'($urandom);
        id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
        id_funct = 6'($urandom);
    endtask

    task automatic set_op(input logic [12:0] c, input logic [15:0] imm);
        rand_id();
        id_ctrl = c;
        id_imm = imm;
        id_valid = 1; stall = 0; flush = 0;
    endtask

    initial begin
        logic [12:0] xc;
        logic [12:0] held_ctrl;
        logic [31:0] held_pc4;
`ifdef IDEX_PERF_CNT_EN
        logic [31:0] cnt0;
`endif
        rst_n = 0; stall = 0; flush = 0; id_valid = 0;
        rand_id();
        #12;
        chk("reset_valid", 64'(ex_valid), 64'd0);
        chk("reset_ctrl", 64'(ex_ctrl), 64'd0);
        rst_n = 1;

        // LW: sign-extend a negative offset
        set_op(13'h0F02, 16'hFFFC);
        cyc();
        chk("lw_imm", 64'(ex_imm_ext), 64'hFFFF_FFFC);
        chk("lw_valid", 64'(ex_valid), 64'd1);

        // ORI: zero-extend
        set_op(13'h0A00, 16'h8001);
        cyc();
        chk("ori_imm", 64'(ex_imm_ext), 64'h0000_8001);

        // Async reset mid-stream, no clock edge
        #2 rst_n = 0;
        #1;
        chk("async_valid", 64'(ex_valid), 64'd0);
        chk("async_data", {ex_pc4, ex_imm_ext}, 64'd0);
        rst_n = 1;
        set_op(13'h1212, 16'h0004);
        cyc();
        chk("post_rst_pc4", 64'(ex_pc4), 64'(id_pc4));
        chk("post_rst_valid", 64'(ex_valid), 64'd1);

        // R-type held through three stalls with changing inputs
        held_ctrl = ex_ctrl;
        held_pc4 = ex_pc4;
`ifdef IDEX_PERF_CNT_EN
        cnt0 = stall_cnt;
`endif
        for (int i = 0; i < 3; i++) begin
            rand_id();
            stall = 1;
            cyc();
            chk("stall_ctrl", 64'(ex_ctrl), 64'(held_ctrl));
            chk("stall_pc4", 64'(ex_pc4), 64'(held_pc4));
        end
`ifdef IDEX_PERF_CNT_EN
        chk("stall_cnt3", 64'(stall_cnt - cnt0), 64'd3);
        cnt0 = bubble_cnt;
`endif

        // Flush wins over stall
        stall = 1; flush = 1;
        cyc();
        chk("flush_valid", 64'(ex_valid), 64'd0);
        chk("flush_ctrl", 64'(ex_ctrl), 64'd0);
`ifdef IDEX_PERF_CNT_EN
        chk("bubble_cnt1", 64'(bubble_cnt - cnt0), 64'd1);
`endif

        // Unknown RegWrite/MemWrite from an undecoded opcode
        xc = 13'h0002;
        xc[9] = 1'bx;
        xc[7] = 1'bx;
        set_op(xc, 16'h0010);
        cyc();
        chk("xscrub_valid", 64'(ex_valid), 64'd1);
        id_valid = 0;
        cyc();
        chk("invalid_valid", 64'(ex_valid), 64'd0);
        chk("invalid_ctrl", 64'(ex_ctrl), 64'd0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            rand_id();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 6) == 0);
            id_valid = ($urandom_range(0, 4) != 0);
            cyc();
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
